// File: rtl/ahbl_sample_fifo.sv
// ahbl_sample_fifo: AHB-Lite slave buffering I2S samples for CPU reads, with a level-threshold IRQ.
// Optional AHBL_SAMPLE_FIFO_PEAK_EN adds a clear-on-read peak |sample| register at 0x14.
module ahbl_sample_fifo #(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int SAMPLE_W = 24
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic [31:0]         HADDR,
    input  logic [1:0]          HTRANS,
    input  logic [2:0]          HSIZE,
    input  logic                HWRITE,
    input  logic                HREADY,
    input  logic                HSEL,
    input  logic [31:0]         HWDATA,
    output logic                HREADYOUT,
    output logic [31:0]         HRDATA,
    input  logic                S_VALID,
    input  logic [SAMPLE_W-1:0] S_DATA,
    output logic                IRQ
);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_HALF = (AW+1)'(DEPTH / 2);
    localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);

    logic [2:0]          addr_q, addr_d;
    logic                wr_q, wr_d, act_q, act_d;
    logic [AW:0]         wp_q, wp_d, rp_q, rp_d, thr_q, thr_d, level;
    logic                en_q, en_d, ie_q, ie_d, ovf_q, ovf_d, udf_q, udf_d, irq_q, irq_d;
    logic [SAMPLE_W-1:0] mem_q [DEPTH];
    logic                rd_sel, wr_sel, rd_data, empty, full, pop, push, accept, flush, irq_pend;
    logic [31:0]         head;
    logic                unused_bits;

    assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HSIZE, HWDATA[31:AW+1]};
    assign HREADYOUT   = 1'b1;
    assign IRQ         = irq_q;

    always_comb begin
        act_d    = HSEL & HTRANS[1] & HREADY;
        addr_d   = HREADY ? HADDR[4:2] : addr_q;
        wr_d     = HREADY ? HWRITE : wr_q;
        level    = wp_q - rp_q;
        empty    = (level == '0);
        full     = (level == LVL_FULL);
        rd_sel   = act_q & ~wr_q;
        wr_sel   = act_q & wr_q;
        rd_data  = rd_sel & (addr_q == 3'd0);
        flush    = wr_sel & (addr_q == 3'd2) & HWDATA[2];
        pop      = rd_data & ~empty;
        push     = S_VALID & en_q;
        accept   = push & (~full | pop) & ~flush;
        rp_d     = flush ? '0 : rp_q + (AW+1)'(pop);
        wp_d     = flush ? '0 : wp_q + (AW+1)'(accept);
        en_d     = (wr_sel & (addr_q == 3'd2)) ? HWDATA[0] : en_q;
        ie_d     = (wr_sel & (addr_q == 3'd2)) ? HWDATA[1] : ie_q;
        thr_d    = !(wr_sel & (addr_q == 3'd3)) ? thr_q :
                   (HWDATA[AW:0] == '0)         ? LVL_ONE :
                   (HWDATA[AW:0] > LVL_FULL)    ? LVL_FULL : HWDATA[AW:0];
        // a new event wins over a same-cycle W1C so it is never lost
        ovf_d    = (ovf_q & ~(wr_sel & (addr_q == 3'd4) & HWDATA[0])) | (push & full & ~pop & ~flush);
        udf_d    = (udf_q & ~(wr_sel & (addr_q == 3'd4) & HWDATA[1])) | (rd_data & empty);
        irq_pend = (level >= thr_q) | ovf_q;
        irq_d    = ie_q & irq_pend;
        head     = 32'($signed(mem_q[rp_q[AW-1:0]]));
    end

`ifdef AHBL_SAMPLE_FIFO_PEAK_EN
    logic [SAMPLE_W-1:0] peak_q, peak_d, mag, mag_sat;
    logic                peak_rd;

    always_comb begin
        mag     = S_DATA[SAMPLE_W-1] ? -S_DATA : S_DATA;
        mag_sat = mag[SAMPLE_W-1] ? {1'b0, {(SAMPLE_W-1){1'b1}}} : mag;
        peak_rd = rd_sel & (addr_q == 3'd5);
        peak_d  = peak_rd                        ? (accept ? mag_sat : '0) :
                  (accept && (mag_sat > peak_q)) ? mag_sat : peak_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) peak_q <= '0;
        else          peak_q <= peak_d;
    end
`endif

    always_comb begin
        HRDATA = '0;
        if (rd_sel) begin
            case (addr_q)
                3'd0:    HRDATA = empty ? '0 : head;
                3'd1:    HRDATA = {11'b0, irq_pend, udf_q, ovf_q, full, empty, 16'(level)};
                3'd2:    HRDATA = {30'b0, ie_q, en_q};
                3'd3:    HRDATA = 32'(thr_q);
`ifdef AHBL_SAMPLE_FIFO_PEAK_EN
                3'd5:    HRDATA = 32'(peak_q);
`endif
                default: HRDATA = '0;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q <= '0;
            wr_q   <= 1'b0;
            act_q  <= 1'b0;
            wp_q   <= '0;
            rp_q   <= '0;
            thr_q  <= LVL_HALF;
            en_q   <= 1'b0;
            ie_q   <= 1'b0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            wr_q   <= wr_d;
            act_q  <= act_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            thr_q  <= thr_d;
            en_q   <= en_d;
            ie_q   <= ie_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
            irq_q  <= irq_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (accept) mem_q[wp_q[AW-1:0]] <= S_DATA;
    end
endmodule

// File: tb/tb_ahbl_sample_fifo.sv
// tb_ahbl_sample_fifo: directed scoreboard bench for ahbl_sample_fifo.
// Reads queue their expected HRDATA/IRQ; a monitor compares in each read data phase.
module tb_ahbl_sample_fifo;
    logic        HCLK = 1'b0, HRESETn = 1'b0;
    logic [31:0] HADDR = '0, HWDATA = '0;
    logic [1:0]  HTRANS = '0;
    logic [2:0]  HSIZE = 3'b010;
    logic        HWRITE = 1'b0, HREADY = 1'b1, HSEL = 1'b0;
    logic        HREADYOUT, IRQ;
    logic [31:0] HRDATA;
    logic        S_VALID = 1'b0;
    logic [23:0] S_DATA = '0;

    typedef struct {
        string       name;
        logic [31:0] data;
        bit          chk_irq;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_pass = 0;
    logic rd_dp = 1'b0;

    ahbl_sample_fifo dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
        .HWRITE(HWRITE), .HREADY(HREADY), .HSEL(HSEL), .HWDATA(HWDATA),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .S_VALID(S_VALID), .S_DATA(S_DATA), .IRQ(IRQ)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) rd_dp <= 1'b0;
        else          rd_dp <= HSEL && HTRANS[1] && !HWRITE && HREADY;
    end

    always @(negedge HCLK) begin
        exp_t e;
        if (rd_dp) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL sb_empty: read data phase with no expected entry");
            end else begin
                e = sb.pop_front();
                check(e.name, HRDATA, e.data);
                if (e.chk_irq) check({e.name, "_irq"}, 32'(IRQ), 32'(e.irq));
            end
        end
    end

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input string nm, input logic [31:0] exp,
                      input bit ci = 0, input logic ie = 0, input bit pv = 0, input logic [23:0] pd = '0);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        sb.push_back('{name: nm, data: exp, chk_irq: ci, irq: ie});
        cyc();
        HSEL = 1'b0; HTRANS = 2'b00;
        if (pv) begin S_VALID = 1'b1; S_DATA = pd; end
        cyc();
        S_VALID = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        cyc();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        cyc();
    endtask

    task automatic push(input logic [23:0] d);
        S_VALID = 1'b1; S_DATA = d;
        cyc();
        S_VALID = 1'b0;
    endtask

    initial begin
        repeat (2) cyc();
        check("rst_hrdata", HRDATA, 32'h0);
        check("rst_irq", 32'(IRQ), 32'h0);
        check("rst_hreadyout", 32'(HREADYOUT), 32'h1);
        HRESETn = 1'b1;
        cyc();
        rd(32'h04, "rst_status", 32'h0001_0000, 1, 0);
        wr(32'h08, 32'h1);
        push(24'h7FFFFF);
        push(24'h800000);
        rd(32'h04, "t2_level", 32'h0000_0002);
        rd(32'h00, "t2_pos", 32'h007F_FFFF);
        rd(32'h00, "t2_neg", 32'hFF80_0000);
        rd(32'h04, "t2_empty", 32'h0001_0000);
        for (int i = 1; i <= 17; i++) push(24'(i * 'h111));
        rd(32'h04, "t3_full_ovf", 32'h0016_0010, 1, 0);
        rd(32'h00, "t3_first", 32'h0000_0111);
        push(24'h0ABCDE);
        wr(32'h10, 32'h1);
        rd(32'h04, "t5_pre", 32'h0012_0010);
        rd(32'h00, "t5_pop_push", 32'h0000_0222, 0, 0, 1, 24'h0FEDCB);
        rd(32'h04, "t5_status", 32'h0012_0010);
        for (int i = 3; i <= 16; i++) rd(32'h00, "t5_drain", 32'(i * 'h111));
        rd(32'h00, "t5_tail0", 32'h000A_BCDE);
        rd(32'h00, "t5_tail1", 32'h000F_EDCB);
        rd(32'h04, "t5_empty", 32'h0001_0000);
        wr(32'h0C, 32'h4);
        rd(32'h0C, "t4_thr", 32'h4);
        wr(32'h08, 32'h3);
        push(24'd1);
        push(24'd2);
        push(24'd3);
        rd(32'h04, "t4_lvl3", 32'h0000_0003, 1, 0);
        push(24'd4);
        check("t4_irq_delay", 32'(IRQ), 32'h0);
        rd(32'h04, "t4_lvl4", 32'h0010_0004, 1, 1);
        rd(32'h00, "t4_pop", 32'h1, 1, 1);
        rd(32'h04, "t4_after_pop", 32'h0000_0003, 1, 0);
        rd(32'h00, "t4_d2", 32'h2);
        rd(32'h00, "t4_d3", 32'h3);
        rd(32'h00, "t4_d4", 32'h4);
        rd(32'h00, "t6_empty_rd", 32'h0);
        rd(32'h04, "t6_udf", 32'h0009_0000, 1, 0);
        wr(32'h10, 32'h2);
        rd(32'h04, "t6_udf_clr", 32'h0001_0000);
        for (int i = 0; i < 5; i++) push(24'(i + 'h10));
        rd(32'h04, "t6_lvl5", 32'h0010_0005, 1, 1);
        wr(32'h08, 32'h7);
        rd(32'h04, "t6_flush", 32'h0001_0000, 1, 0);
        rd(32'h08, "t6_ctrl", 32'h3);
        rd(32'h00, "t7_empty_push", 32'h0, 0, 0, 1, 24'h000055);
        rd(32'h04, "t7_status", 32'h0008_0001, 1, 0);
        rd(32'h00, "t7_stored", 32'h0000_0055);
        wr(32'h10, 32'h2);
        wr(32'h0C, 32'h0);
        rd(32'h0C, "thr_zero", 32'h1);
        rd(32'h1C, "unmapped", 32'h0);
        wr(32'h08, 32'h0);
        push(24'h000005);
        rd(32'h04, "en_off", 32'h0001_0000);
        wr(32'h08, 32'h1);
        push(24'h000007);
        push(24'h000008);
        HRESETn = 1'b0;
        #2;
        check("midrst_hrdata", HRDATA, 32'h0);
        cyc();
        HRESETn = 1'b1;
        cyc();
        rd(32'h04, "midrst_status", 32'h0001_0000, 1, 0);
        rd(32'h0C, "midrst_thr", 32'h8);
        rd(32'h08, "midrst_ctrl", 32'h0);
        repeat (3) cyc();
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL sb_leftover: %0d expected reads never compared", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
